// File: rtl/crc_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : crc_frame_sequencer                                        |
// | Description : Walks a received frame byte by byte through an external    |
// |               CRC-16 engine, then compares the result with the two CRC   |
// |               bytes that close the frame.                                |
// | Option      : define CRC_SEQ_TIMEOUT_EN to add the engine-handshake      |
// |               watchdog and its timeout_err output.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module crc_frame_sequencer #(
   parameter int MAX_LEN = 32,
   parameter int TMO_CYC = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_valid,
   input  logic [5:0]  frame_len,
   output logic [5:0]  rd_addr,
   input  logic [7:0]  rd_data,
   output logic        crc_clr,
   output logic        crc_start,
   output logic [7:0]  crc_byte,
   input  logic        crc_busy,
   input  logic [15:0] crc_value,
   output logic        busy,
   output logic        done,
   output logic        crc_ok,
   output logic        len_err,
`ifdef CRC_SEQ_TIMEOUT_EN
   output logic        timeout_err,
`endif
   output logic [15:0] crc_out
);

   localparam logic [3:0] c_IDLE    = 4'd0;
   localparam logic [3:0] c_CLEAR   = 4'd1;
   localparam logic [3:0] c_FETCH   = 4'd2;
   localparam logic [3:0] c_LOAD    = 4'd3;
   localparam logic [3:0] c_STROBE  = 4'd4;
   localparam logic [3:0] c_WAIT_HI = 4'd5;
   localparam logic [3:0] c_WAIT_LO = 4'd6;
   localparam logic [3:0] c_CAPT_LO = 4'd7;
   localparam logic [3:0] c_CAPT_HI = 4'd8;
   localparam logic [3:0] c_COMPARE = 4'd9;
   localparam logic [3:0] c_DONE    = 4'd10;

   logic [3:0] r_state;
   logic [5:0] r_len;
   logic [5:0] r_index;
   logic [7:0] r_crc_lo;

   logic [5:0] w_index_next;
   logic [5:0] w_payload_len;
   logic       w_len_bad;
   logic       w_tmo_hit;

   assign w_index_next  = r_index + 6'd1;
   assign w_payload_len = r_len - 6'd2;
   // Shortest useful frame is one payload byte plus the two CRC bytes.
   assign w_len_bad     = (frame_len < 6'd3) || ({26'd0, frame_len} > MAX_LEN);

`ifdef CRC_SEQ_TIMEOUT_EN
   localparam int c_TMO_W = $clog2(TMO_CYC + 1);

   logic [c_TMO_W-1:0] r_tmo_cnt;

   assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(TMO_CYC - 1));

   // Counts consecutive cycles spent waiting on one engine handshake edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tmo_cnt <= '0;
      end else if (((r_state == c_WAIT_HI) && !crc_busy) ||
                   ((r_state == c_WAIT_LO) && crc_busy)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
         r_tmo_cnt <= '0;
      end
   end
`else
   assign w_tmo_hit = 1'b0;

   // Without the watchdog TMO_CYC has no effect; keep it referenced.
   if (TMO_CYC < 1) begin : g_tmo_cfg_ignored
   end
`endif

   // Frame sequencing: clear engine, feed payload bytes, capture and compare CRC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= c_IDLE;
         r_len     <= '0;
         r_index   <= '0;
         r_crc_lo  <= '0;
         rd_addr   <= '0;
         crc_clr   <= 1'b0;
         crc_start <= 1'b0;
         crc_byte  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         crc_ok    <= 1'b0;
         len_err   <= 1'b0;
         crc_out   <= '0;
`ifdef CRC_SEQ_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
      end else begin
         crc_clr <= 1'b0;
         done    <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (frame_valid) begin
                  r_len   <= frame_len;
                  crc_ok  <= 1'b0;
                  len_err <= w_len_bad;
                  busy    <= 1'b1;
`ifdef CRC_SEQ_TIMEOUT_EN
                  timeout_err <= 1'b0;
`endif
                  if (w_len_bad) begin
                     r_state <= c_DONE;
                  end else begin
                     // Engine clear is visible during the CLEAR cycle only.
                     crc_clr <= 1'b1;
                     r_state <= c_CLEAR;
                  end
               end
            end
            c_CLEAR: begin
               r_index <= '0;
               rd_addr <= '0;
               r_state <= c_FETCH;
            end
            c_FETCH: begin
               // rd_addr already holds the index; data returns next cycle.
               r_state <= c_LOAD;
            end
            c_LOAD: begin
               crc_byte <= rd_data;
               r_state  <= c_STROBE;
            end
            c_STROBE: begin
               crc_start <= 1'b1;
               r_state   <= c_WAIT_HI;
            end
            c_WAIT_HI: begin
               if (crc_busy) begin
                  crc_start <= 1'b0;
                  r_state   <= c_WAIT_LO;
               end else if (w_tmo_hit) begin
                  crc_start <= 1'b0;
                  crc_ok    <= 1'b0;
`ifdef CRC_SEQ_TIMEOUT_EN
                  timeout_err <= 1'b1;
`endif
                  r_state   <= c_DONE;
               end
            end
            c_WAIT_LO: begin
               if (!crc_busy) begin
                  r_index <= w_index_next;
                  if (w_index_next < w_payload_len) begin
                     rd_addr <= w_index_next;
                     r_state <= c_FETCH;
                  end else begin
                     rd_addr <= w_payload_len;
                     r_state <= c_CAPT_LO;
                  end
               end else if (w_tmo_hit) begin
                  crc_ok  <= 1'b0;
`ifdef CRC_SEQ_TIMEOUT_EN
                  timeout_err <= 1'b1;
`endif
                  r_state <= c_DONE;
               end
            end
            c_CAPT_LO: begin
               // Low CRC byte address is on the bus; request the high byte next.
               rd_addr <= r_len - 6'd1;
               r_state <= c_CAPT_HI;
            end
            c_CAPT_HI: begin
               r_crc_lo <= rd_data;
               r_state  <= c_COMPARE;
            end
            c_COMPARE: begin
               crc_out <= crc_value;
               crc_ok  <= (crc_value == {rd_data, r_crc_lo});
               r_state <= c_DONE;
            end
            c_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_crc_frame_sequencer                                     |
// | Description : Bench for crc_frame_sequencer with a receive-buffer model  |
// |               and a bit-serial CRC-16 engine model.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_crc_frame_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_valid;
   logic [5:0]  frame_len;
   logic [5:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        crc_clr;
   logic        crc_start;
   logic [7:0]  crc_byte;
   logic        crc_busy;
   logic [15:0] crc_value;
   logic        busy;
   logic        done;
   logic        crc_ok;
   logic        len_err;
   logic [15:0] crc_out;
`ifdef CRC_SEQ_TIMEOUT_EN
   logic        timeout_err;
`endif

   crc_frame_sequencer #(.MAX_LEN(32), .TMO_CYC(64)) dut (
      .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_len(frame_len),
      .rd_addr(rd_addr), .rd_data(rd_data), .crc_clr(crc_clr), .crc_start(crc_start),
      .crc_byte(crc_byte), .crc_busy(crc_busy), .crc_value(crc_value), .busy(busy),
      .done(done), .crc_ok(crc_ok), .len_err(len_err),
`ifdef CRC_SEQ_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .crc_out(crc_out)
   );

   always #5 clk = ~clk;

   // Receive buffer: one-cycle read latency.
   logic [7:0] mem [0:63];
   always @(posedge clk) rd_data <= mem[rd_addr];

   // CRC-16/MODBUS engine: start seen through 2 flops, 8 bit-steps per byte.
   logic [15:0] e_crc = 16'hFFFF;
   logic        e_busy = 1'b0;
   logic [3:0]  e_cnt = 4'd0;
   logic        e_s1 = 1'b0, e_s2 = 1'b0, e_s3 = 1'b0;
   logic        tb_stuck = 1'b0;

   function automatic logic [15:0] crc_step(input logic [15:0] c);
      return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
   endfunction

   always @(posedge clk) begin
      e_s1 <= crc_start;
      e_s2 <= e_s1;
      e_s3 <= e_s2;
      if (crc_clr) begin
         e_crc <= 16'hFFFF; e_busy <= 1'b0; e_cnt <= 4'd0;
      end else if (e_busy) begin
         e_crc <= crc_step(e_crc);
         e_cnt <= e_cnt - 4'd1;
         if (e_cnt == 4'd1) e_busy <= 1'b0;
      end else if (e_s2 && !e_s3 && !tb_stuck) begin
         e_crc  <= e_crc ^ {8'h00, crc_byte};
         e_busy <= 1'b1;
         e_cnt  <= 4'd8;
      end
   end
   assign crc_busy  = e_busy;
   assign crc_value = e_crc;

   // Reference CRC over mem[0 .. n-1].
   function automatic logic [15:0] ref_crc(input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, mem[i]};
         for (int b = 0; b < 8; b++) c = crc_step(c);
      end
      return c;
   endfunction

   typedef struct {
      logic [15:0] crc;
      logic        ok;
      logic        err;
      logic        tmo;
      int          strobes;
      bit          chk_crc;
      int          base;
   } exp_t;

   typedef struct {
      logic [15:0] crc;
      logic        ok;
      logic        err;
      logic        tmo;
      int          strobe_total;
   } act_t;

   exp_t exp_q[$];
   act_t act_q[$];

   int checks = 0;
   int failures = 0;

   // Monitor: strobe edges, clear ordering and done results.
   int   strobe_total = 0;
   int   done_total = 0;
   logic start_prev = 1'b0;
   logic clr_seen = 1'b0;
   logic first_strobe_seen = 1'b0;
   logic clr_before_first = 1'b0;

   always @(negedge clk) begin
      act_t a;
      if (reset) begin
         clr_seen = 1'b0;
         first_strobe_seen = 1'b0;
      end else begin
         if (crc_clr) clr_seen = 1'b1;
         if (crc_start && !start_prev) begin
            strobe_total++;
            if (!first_strobe_seen) begin
               first_strobe_seen = 1'b1;
               clr_before_first = clr_seen;
            end
         end
         if (done) begin
            done_total++;
            a.crc = crc_out; a.ok = crc_ok; a.err = len_err; a.strobe_total = strobe_total;
`ifdef CRC_SEQ_TIMEOUT_EN
            a.tmo = timeout_err;
`else
            a.tmo = 1'b0;
`endif
            act_q.push_back(a);
         end
      end
      start_prev = crc_start;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pulse(input int len);
      @(negedge clk);
      frame_len = 6'(len);
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   // Build payload plus appended CRC (optionally corrupted) and return the CRC.
   task automatic build(input int len, input int seed, input bit corrupt, output logic [15:0] c);
      c = 16'h0000;
      if (len >= 3) begin
         for (int i = 0; i < len - 2; i++) mem[i] = 8'((seed * 37 + i * 13 + 5) & 255);
         c = ref_crc(len - 2);
         mem[len-2] = c[7:0];
         mem[len-1] = c[15:8] ^ {7'd0, corrupt};
      end
   endtask

   task automatic load_spec(input logic [7:0] last);
      mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h00; mem[3] = 8'h00;
      mem[4] = 8'h00; mem[5] = 8'h01; mem[6] = 8'h84; mem[7] = last;
   endtask

   task automatic push_exp(input logic [15:0] c, input logic ok, input logic err,
                           input logic tmo, input int strobes, input bit chk_crc);
      exp_t e;
      e.crc = c; e.ok = ok; e.err = err; e.tmo = tmo;
      e.strobes = strobes; e.chk_crc = chk_crc; e.base = strobe_total;
      exp_q.push_back(e);
   endtask

   // Wait for every outstanding expectation, then compare in order.
   task automatic drain(input string tag);
      exp_t e;
      act_t a;
      for (int i = 0; i < 3000 && act_q.size() < exp_q.size(); i++) begin
         @(negedge clk);
         #1;
      end
      if (act_q.size() < exp_q.size()) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=%0d required=%0d dones", tag, act_q.size(), exp_q.size());
         exp_q.delete();
         act_q.delete();
      end
      while (exp_q.size() > 0 && act_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         chk({tag, "_crc_ok"}, 32'(a.ok), 32'(e.ok));
         chk({tag, "_len_err"}, 32'(a.err), 32'(e.err));
         chk({tag, "_strobes"}, 32'(a.strobe_total - e.base), 32'(e.strobes));
         if (e.chk_crc) chk({tag, "_crc_out"}, 32'(a.crc), 32'(e.crc));
`ifdef CRC_SEQ_TIMEOUT_EN
         chk({tag, "_timeout_err"}, 32'(a.tmo), 32'(e.tmo));
`endif
      end
      if (act_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL %s_spurious_done actual=%0d required=0 extra", tag, act_q.size());
         act_q.delete();
      end
   endtask

   typedef struct {
      int len;
      int seed;
      bit corrupt;
      bit err;
   } vec_t;

   vec_t vt[10];

   initial begin
      logic [15:0] c;
      int base;
      int lat;
      int d0;

      vt[0] = '{3, 1, 1'b0, 1'b0};
      vt[1] = '{3, 2, 1'b1, 1'b0};
      vt[2] = '{5, 3, 1'b0, 1'b0};
      vt[3] = '{32, 4, 1'b0, 1'b0};
      vt[4] = '{32, 5, 1'b1, 1'b0};
      vt[5] = '{2, 0, 1'b0, 1'b1};
      vt[6] = '{33, 0, 1'b0, 1'b1};
      vt[7] = '{40, 0, 1'b0, 1'b1};
      vt[8] = '{0, 0, 1'b0, 1'b1};
      vt[9] = '{16, 6, 1'b0, 1'b0};

      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      reset = 1'b1;
      frame_valid = 1'b0;
      frame_len = 6'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_crc_ok", 32'(crc_ok), 0);
      chk("rst_len_err", 32'(len_err), 0);
      chk("rst_crc_start", 32'(crc_start), 0);
      chk("rst_crc_clr", 32'(crc_clr), 0);
      chk("rst_crc_out", 32'(crc_out), 0);
      chk("rst_crc_byte", 32'(crc_byte), 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Reference Modbus frame, then the same frame with a bad CRC high byte.
      load_spec(8'h0A);
      push_exp(16'h0A84, 1'b1, 1'b0, 1'b0, 6, 1'b1);
      pulse(8);
      drain("spec_good");
      chk("spec_clr_first", 32'(clr_before_first), 1);
      load_spec(8'h0B);
      push_exp(16'h0A84, 1'b0, 1'b0, 1'b0, 6, 1'b1);
      pulse(8);
      drain("spec_bad");

      // Table of lengths, payloads and corruptions, including length limits.
      for (int v = 0; v < 10; v++) begin
         build(vt[v].len, vt[v].seed, vt[v].corrupt, c);
         if (vt[v].err)
            push_exp(16'h0000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
         else
            push_exp(c, !vt[v].corrupt, 1'b0, 1'b0, vt[v].len - 2, 1'b1);
         pulse(vt[v].len);
         drain($sformatf("vec%0d", v));
      end

      // Illegal length: done within 1-2 cycles of frame_valid.
      @(negedge clk);
      frame_len = 6'd2;
      frame_valid = 1'b1;
      lat = 0;
      for (int i = 0; i < 10 && !(done === 1'b1); i++) begin
         @(negedge clk);
         frame_valid = 1'b0;
         lat++;
      end
      frame_valid = 1'b0;
      chk("len_err_latency_ok", 32'((lat >= 1) && (lat <= 2)), 1);
      repeat (3) @(negedge clk);
      act_q.delete();

      // Reset during the third byte, then a clean reference frame.
      load_spec(8'h0A);
      base = strobe_total;
      pulse(8);
      for (int i = 0; i < 500 && (strobe_total - base) < 3; i++) @(negedge clk);
      chk("abort_reached_byte3", 32'(strobe_total - base), 3);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_crc_start", 32'(crc_start), 0);
      chk("abort_crc_out", 32'(crc_out), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", 32'(act_q.size()), 0);
      act_q.delete();
      push_exp(16'h0A84, 1'b1, 1'b0, 1'b0, 6, 1'b1);
      pulse(8);
      drain("after_reset");
      chk("after_reset_clr_first", 32'(clr_before_first), 1);

      // Second frame_valid while busy must be ignored.
      d0 = done_total;
      push_exp(16'h0A84, 1'b1, 1'b0, 1'b0, 6, 1'b1);
      pulse(8);
      repeat (6) @(negedge clk);
      frame_len = 6'd2;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      drain("repulse");
      repeat (20) @(negedge clk);
      chk("repulse_done_count", 32'(done_total - d0), 1);

`ifdef CRC_SEQ_TIMEOUT_EN
      // Engine never goes busy: watchdog ends the frame.
      tb_stuck = 1'b1;
      push_exp(16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      pulse(8);
      drain("timeout");
      tb_stuck = 1'b0;
      push_exp(16'h0A84, 1'b1, 1'b0, 1'b0, 6, 1'b1);
      pulse(8);
      drain("post_timeout");
`endif

      repeat (5) @(negedge clk);
      if (act_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL final_spurious_done actual=%0d required=0", act_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
